acc_ctrl: RTL
=============

ACC_CTRL -- requirements
Module: acc_ctrl

Interface
REQ-001 SHALL have parameter: ALU_LAT, 1, number of cycles alu_a/alu_b/alu_sel are held before alu_out is captured (legal 1..4).
REQ-002 SHALL have port: clock  in  1  single clock, all state updates on posedge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  in  1  command offered.
REQ-005 SHALL have port: cmd_ready  out  1  command accepted when both high at posedge.
REQ-006 SHALL have port: cmd_load  in  1  1 = load cmd_operand directly into accumulator, no ALU access.
REQ-007 SHALL have ports: cmd_sel  in  4  ALU opcode; cmd_operand  in  4  operand b.
REQ-008 SHALL have ports: alu_a  out  4; alu_b  out  4; alu_sel  out  4  drive the combinational ALU.
REQ-009 SHALL have port: alu_out  in  4  ALU result.
REQ-010 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  4  result handshake.
REQ-011 SHALL have port: acc  out  4  current accumulator value.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, RESP; cmd_ready = 1 only in IDLE.
REQ-013 On accept with cmd_load=1 at edge E0: acc <= cmd_operand, IDLE->RESP; rsp_valid high after E0.
REQ-014 On accept with cmd_load=0 at edge E0: latch cmd_sel/cmd_operand, IDLE->ISSUE.
REQ-015 In ISSUE: alu_a=acc, alu_b=latched operand, alu_sel=latched sel, all registered and stable for exactly ALU_LAT cycles.
REQ-016 At edge E0+ALU_LAT: acc <= alu_out, ISSUE->RESP; rsp_valid high after that edge.
REQ-017 Latched sel=0 (NOP): skip ISSUE, acc unchanged, IDLE->RESP as in REQ-013.
REQ-018 Outside ISSUE: alu_sel=0, alu_b=0, alu_a=acc.
REQ-019 In RESP: rsp_valid=1, rsp_data=acc, held stable until rsp_valid&rsp_ready at a posedge, then ->IDLE.
REQ-020 cmd_valid in RESP/ISSUE is ignored (no accept); back-to-back commands need one IDLE cycle.
REQ-021 All arithmetic is 4-bit; alu_out captured unmodified, no width extension.

Reset
REQ-022 While reset high: state IDLE, acc=0, alu_a=alu_b=alu_sel=0, rsp_valid=0, rsp_data=0, cmd_ready=0.
REQ-023 First posedge after reset deasserts: cmd_ready=1.
REQ-024 Reset in ISSUE or RESP abandons the operation; no response is ever issued for it.

Configuration
REQ-025 Macro ACC_CTRL_SWEEP_EN defined: add ports sweep_start in 1, sweep_busy out 1.
REQ-026 With macro: sweep_start sampled in IDLE only when cmd_valid=0 (cmd_valid wins); latches cmd_operand as b.
REQ-027 Sweep issues alu_sel 1,2,...,8 in order, each for ALU_LAT cycles back-to-back, acc updated after each step; single RESP after sel 8.
REQ-028 sweep_busy high from sweep accept edge until the RESP handshake; cmd_ready=0 throughout.
REQ-029 Without macro: no sweep ports, no sweep logic; sweep_start behaviour absent.

Structure
REQ-030 Package acc_ctrl_pkg SHALL hold state enum, DW=4, SEL_NOP=0, SWEEP_FIRST=1, SWEEP_LAST=8.
REQ-031 Sub-module acc_sweep_gen (sel counter 1..8, done flag) SHALL be instantiated only under ACC_CTRL_SWEEP_EN.

Verification
REQ-032 Reset, cmd_load=1 operand 2 -> rsp_valid one cycle after accept, rsp_data=2, acc=2.
REQ-033 acc=2, cmd sel=7 operand 3, ALU_LAT=1 -> alu_a=2, alu_b=3, alu_sel=7 for exactly 1 cycle; rsp_data=model(2,3,7).
REQ-034 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data stable, cmd_ready=0; completes on rsp_ready=1.
REQ-035 cmd sel=0 operand 5 -> alu_sel stays 0, rsp_data=acc unchanged.
REQ-036 Reset asserted mid-ISSUE (ALU_LAT=3) -> outputs at reset values immediately, no rsp_valid afterwards.
REQ-037 Sweep (macro on) acc=2, operand 3 -> alu_sel 1..8 each ALU_LAT cycles, one response = chained model result.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared types and constants for the accumulator controller.
package acc_ctrl_pkg;

    localparam int DW = 4;

    typedef logic [DW-1:0] word_t;

    localparam word_t SEL_NOP     = word_t'(0);
    localparam word_t SWEEP_FIRST = word_t'(1);
    localparam word_t SWEEP_LAST  = word_t'(8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/acc_sweep_gen.sv
// Opcode sequencer for the sweep operation: walks alu_sel from SWEEP_FIRST
// to SWEEP_LAST, one step per completed ALU slot. Only built when
// ACC_CTRL_SWEEP_EN is defined.
`ifdef ACC_CTRL_SWEEP_EN
module acc_sweep_gen
    import acc_ctrl_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  start_i,  // begin a new sweep at SWEEP_FIRST
    input  logic  step_i,   // current opcode slot has finished
    output word_t sel_o,    // opcode to drive; SEL_NOP when idle
    output logic  last_o    // current opcode is the final one
);

    word_t sel_q, sel_d;

    // Next opcode: restart, advance, or drop back to NOP after the last one.
    always_comb begin
        sel_d = sel_q;
        if (start_i) begin
            sel_d = SWEEP_FIRST;
        end else if (step_i) begin
            sel_d = (sel_q == SWEEP_LAST) ? SEL_NOP : sel_q + word_t'(1);
        end
    end

    // Opcode register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_q <= SEL_NOP;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel_o  = sel_q;
    assign last_o = (sel_q == SWEEP_LAST);

endmodule
`endif

// File: rtl/acc_ctrl.sv
// Accumulator controller: accepts load / ALU commands, drives an external
// combinational ALU for ALU_LAT cycles, captures its result into the
// accumulator and returns the new value over a valid/ready response.
// Optional feature macro ACC_CTRL_SWEEP_EN adds a sweep command that chains
// opcodes 1..8 against one operand and responds once at the end.
module acc_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int ALU_LAT = 1  // legal 1..4
)(
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [DW-1:0] cmd_sel,
    input  logic [DW-1:0] cmd_operand,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [DW-1:0] alu_sel,
    input  logic [DW-1:0] alu_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [DW-1:0] acc
`ifdef ACC_CTRL_SWEEP_EN
    ,
    input  logic          sweep_start,
    output logic          sweep_busy
`endif
);

    // Cycle counter within one ALU slot; 3 bits covers ALU_LAT up to 4.
    localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

    state_e     state_q, state_d;
    word_t      acc_q, acc_d;
    word_t      sel_q, sel_d;   // opcode of a single command
    word_t      opb_q, opb_d;   // operand b, zero outside ISSUE
    logic [2:0] cnt_q, cnt_d;
    logic       live_q;         // low until the first edge after reset
    logic       cmd_accept;

`ifdef ACC_CTRL_SWEEP_EN
    logic  busy_q, busy_d;
    logic  sweep_go;
    logic  sweep_begin;
    logic  sweep_step;
    word_t gen_sel;
    logic  gen_last;
`endif

    assign cmd_ready  = live_q && (state_q == ST_IDLE);
    assign cmd_accept = cmd_valid && cmd_ready;

`ifdef ACC_CTRL_SWEEP_EN
    // A real command always takes priority over a sweep request.
    assign sweep_go = cmd_ready && !cmd_valid && sweep_start;
`endif

    // Next-state and datapath update for the command FSM.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
        state_d = state_q;
        acc_d   = acc_q;
        sel_d   = sel_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
`ifdef ACC_CTRL_SWEEP_EN
        busy_d      = busy_q;
        sweep_begin = 1'b0;
        sweep_step  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (cmd_load) begin
                        acc_d   = cmd_operand;
                        state_d = ST_RESP;
                    end else if (cmd_sel == SEL_NOP) begin
                        state_d = ST_RESP;
                    end else begin
                        sel_d   = cmd_sel;
                        opb_d   = cmd_operand;
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
`ifdef ACC_CTRL_SWEEP_EN
                else if (sweep_go) begin
                    opb_d       = cmd_operand;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    sweep_begin = 1'b1;
                    state_d     = ST_ISSUE;
                end
`endif
            end
            ST_ISSUE: begin
                if (cnt_q == LAT_LAST) begin
                    acc_d = alu_out;
                    cnt_d = '0;
`ifdef ACC_CTRL_SWEEP_EN
                    if (busy_q) begin
                        sweep_step = 1'b1;
                        if (gen_last) begin
                            opb_d   = '0;
                            state_d = ST_RESP;
                        end
                    end else
`endif
                    begin
                        sel_d   = SEL_NOP;
                        opb_d   = '0;
                        state_d = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
`ifdef ACC_CTRL_SWEEP_EN
                    busy_d  = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            sel_q   <= SEL_NOP;
            opb_q   <= '0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            acc_q   <= acc_d;
            sel_q   <= sel_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

`ifdef ACC_CTRL_SWEEP_EN
    // Sweep-in-progress flag, held until the response handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    acc_sweep_gen u_sweep_gen (
        .clock   (clock),
        .reset   (reset),
        .start_i (sweep_begin),
        .step_i  (sweep_step),
        .sel_o   (gen_sel),
        .last_o  (gen_last)
    );

    assign sweep_busy = busy_q;
    assign alu_sel    = busy_q ? gen_sel : sel_q;
`else
    assign alu_sel    = sel_q;
`endif

    assign alu_a     = acc_q;
    assign alu_b     = opb_q;
    assign acc       = acc_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = (state_q == ST_RESP) ? acc_q : '0;

endmodule
